// File: rtl/asmd_divider_if.sv
// asmd_divider_if: start/ready handshake and operand/result bus for asmd_divider
//   dividend    2W  numerator, driven by master
//   divisor     W   denominator, driven by master
//   start       1   level request, driven by master
//   quotient    2W  result, driven by slave
//   remainder   W   result, driven by slave
//   ready       1   1 = idle with results holding, driven by slave
//   div_by_zero 1   last accepted op had a zero divisor, driven by slave
interface asmd_divider_if #(parameter int word_length = 4);
    logic [2*word_length-1:0] dividend;
    logic [word_length-1:0]   divisor;
    logic                     start;
    logic [2*word_length-1:0] quotient;
    logic [word_length-1:0]   remainder;
    logic                     ready;
    logic                     div_by_zero;
    modport master(output dividend, divisor, start, input quotient, remainder, ready, div_by_zero);
    modport slave(input dividend, divisor, start, output quotient, remainder, ready, div_by_zero);
endinterface

// File: rtl/asmd_divider.sv
// asmd_divider: sequential restoring divider, 2W-bit dividend by W-bit divisor
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    asmd_divider_if slave: dividend/divisor/start in,
//          quotient/remainder/ready/div_by_zero out
module asmd_divider #(parameter int word_length = 4) (
    input logic clk,
    input logic reset,
    asmd_divider_if.slave bus
);
    localparam int W = word_length;
    localparam int CW = $clog2(2*W+1);
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_n;
    logic [W:0] r, r_n, rs, t;
    logic [2*W-1:0] q, q_n, qs, quo, quo_n;
    logic [W-1:0] d, d_n, rem, rem_n;
    logic [CW-1:0] cnt, cnt_n;
    logic dz, dz_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            r <= '0;
            q <= '0;
            d <= '0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dz <= 1'b0;
        end else begin
            state <= state_n;
            r <= r_n;
            q <= q_n;
            d <= d_n;
            cnt <= cnt_n;
            quo <= quo_n;
            rem <= rem_n;
            dz <= dz_n;
        end
    end
    always_comb begin
        // one shift-subtract step: shift {R,Q} left, try subtracting D
        rs = {r[W-1:0], q[2*W-1]};
        qs = {q[2*W-2:0], 1'b0};
        t = rs - {1'b0, d};
        state_n = state;
        r_n = r;
        q_n = q;
        d_n = d;
        cnt_n = cnt;
        quo_n = quo;
        rem_n = rem;
        dz_n = dz;
        if (state == S_IDLE) begin
            if (bus.start && bus.divisor != '0) begin
                d_n = bus.divisor;
                q_n = bus.dividend;
                r_n = '0;
                cnt_n = CW'(2*W);
                dz_n = 1'b0;
                state_n = S_RUN;
            end else if (bus.start) begin
                // zero divisor resolves immediately without leaving idle
                quo_n = '1;
                rem_n = '0;
                dz_n = 1'b1;
            end
        end else begin
            r_n = t[W] ? rs : t;
            q_n = {qs[2*W-1:1], ~t[W]};
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                quo_n = q_n;
                rem_n = r_n[W-1:0];
                state_n = S_IDLE;
            end
        end
    end
    assign bus.ready = (state == S_IDLE);
    assign bus.quotient = quo;
    assign bus.remainder = rem;
    assign bus.div_by_zero = dz;
endmodule

// File: tb/tb_asmd_divider.sv
// tb_asmd_divider: directed and sweep checks of asmd_divider against a behavioural model
module tb_asmd_divider;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    asmd_divider_if #(.word_length(4)) bus();
    asmd_divider #(.word_length(4)) dut(.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: an accepted op finishes 8 edges later with a/b and a%b
    logic armed = 1'b0;
    logic m_ready, m_dz;
    logic [7:0] m_q, p_q;
    logic [3:0] m_r, p_r;
    int busy;
    always @(posedge clk) begin
        if (reset) begin
            armed <= 1'b1;
            m_ready <= 1'b1;
            m_q <= 8'd0;
            m_r <= 4'd0;
            m_dz <= 1'b0;
            busy <= 0;
        end else if (m_ready && bus.start) begin
            if (bus.divisor == 4'd0) begin
                m_q <= 8'hFF;
                m_r <= 4'd0;
                m_dz <= 1'b1;
            end else begin
                m_ready <= 1'b0;
                busy <= 8;
                p_q <= bus.dividend / {4'd0, bus.divisor};
                p_r <= 4'(bus.dividend % {4'd0, bus.divisor});
                m_dz <= 1'b0;
            end
        end else if (!m_ready) begin
            busy <= busy - 1;
            if (busy == 1) begin
                m_ready <= 1'b1;
                m_q <= p_q;
                m_r <= p_r;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_ready", {31'd0, bus.ready}, {31'd0, m_ready});
            chk("cyc_quotient", {24'd0, bus.quotient}, {24'd0, m_q});
            chk("cyc_remainder", {28'd0, bus.remainder}, {28'd0, m_r});
            chk("cyc_div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, m_dz});
        end
    end

    // one-cycle start pulse, then count busy cycles until ready returns
    task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int n);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus.ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic lit(input string name, input logic [7:0] eq, input logic [3:0] er);
        chk({name, "_q"}, {24'd0, bus.quotient}, {24'd0, eq});
        chk({name, "_r"}, {28'd0, bus.remainder}, {28'd0, er});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.dividend = 8'd0;
        bus.divisor = 4'd0;
        repeat (2) @(negedge clk);
        lit("t1_reset", 8'd0, 4'd0);
        chk("t1_ready", {31'd0, bus.ready}, 32'd1);
        chk("t1_dz", {31'd0, bus.div_by_zero}, 32'd0);
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("t1_ready_after", {31'd0, bus.ready}, 32'd1);
        do_op(8'd6, 4'd2, n);
        chk("t2_busy_len", n, 32'd8);
        lit("t2_6div2", 8'd3, 4'd0);
        do_op(8'd200, 4'd7, n);
        lit("t3_200div7", 8'd28, 4'd4);
        do_op(8'd255, 4'd15, n);
        lit("t3_255div15", 8'd17, 4'd0);
        do_op(8'd1, 4'd15, n);
        lit("t3_1div15", 8'd0, 4'd1);
        do_op(8'd255, 4'd1, n);
        lit("t3_255div1", 8'd255, 4'd0);
        do_op(8'd9, 4'd0, n);
        chk("t4_no_busy", n, 32'd0);
        lit("t4_9div0", 8'hFF, 4'd0);
        chk("t4_dz", {31'd0, bus.div_by_zero}, 32'd1);
        do_op(8'd9, 4'd3, n);
        lit("t4_9div3", 8'd3, 4'd0);
        chk("t4_dz_clear", {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        bus.dividend = 8'd100;
        bus.divisor = 4'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_ready", {31'd0, bus.ready}, 32'd1);
        lit("t5_abort", 8'd0, 4'd0);
        do_op(8'd100, 4'd3, n);
        chk("t5_busy_len", n, 32'd8);
        lit("t5_100div3", 8'd33, 4'd1);
        @(negedge clk);
        bus.dividend = 8'd15;
        bus.divisor = 4'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.dividend = 8'd99;
        bus.divisor = 4'd9;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        lit("t6_15div4", 8'd3, 4'd3);
        repeat (2) @(negedge clk);
        chk("t6_single_op", {31'd0, bus.ready}, 32'd1);
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_op(8'(a), 4'(b), n);
                chk("sweep_invariant",
                    {31'd0, (int'(bus.quotient) * b + int'(bus.remainder) == a) && (int'(bus.remainder) < b)},
                    32'd1);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
